dual_dot_unpack: RTL and testbench

DUAL_DOT_UNPACK -- requirements
Module: dual_dot_unpack

---
 rtl/int8_pack_pkg.sv | 28 ++
 rtl/dual_dot_requant.sv | 43 ++++
 rtl/dual_dot_unpack.sv | 140 ++++++++++++++
 tb/tb_dual_dot_unpack.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int8_pack_pkg.sv
// Purpose : shared field widths and saturation limits for the packed int8 MACC chain.
// Latency : n/a (constants and constant functions only).
// Backpressure: n/a.
//
// P_WIDTH   - width of one packed P word from the DSP cascade.
// JI_W/KI_W - widths of the upper (j) and lower (k) fields of P for a given operand width.
// sat_max/sat_min - signed saturation limits for a given result width.
package int8_pack_pkg;

  localparam int P_WIDTH = 48;

  function automatic int JI_W(input int w);
    return 24 + w;
  endfunction

  function automatic int KI_W(input int w);
    return 24 - w;
  endfunction

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/dual_dot_requant.sv
// Purpose : one-lane requantizer: round-half-up, arithmetic shift right, signed saturate.
// Latency : combinational.
// Backpressure: none (pure function of i_acc).
//
// Ports:
//   i_acc  in  JI_W(WIDTH)+1  signed accumulator (bias already added)
//   o_res  out WIDTH          signed saturated result
module dual_dot_requant
  import int8_pack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = 7
) (
  input  logic [JI_W(WIDTH):0] i_acc,
  output logic [WIDTH-1:0]     o_res
);

  localparam int AW = JI_W(WIDTH) + 1;
  // One guard bit so the rounding constant can never overflow the accumulator.
  localparam int EW = AW + 1;
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [EW-1:0] RND  = (SHIFT > 0) ? (EW'(1) << RS) : '0;
  localparam logic signed [EW-1:0] MAXV = EW'(sat_max(WIDTH));
  localparam logic signed [EW-1:0] MINV = EW'(sat_min(WIDTH));

  logic signed [EW-1:0] w_ext;
  logic signed [EW-1:0] w_rnd;
  logic signed [EW-1:0] w_shr;

  assign w_ext = {i_acc[AW-1], i_acc};
  assign w_rnd = w_ext + RND;
  assign w_shr = w_rnd >>> SHIFT;

  always_comb begin
    o_res = w_shr[WIDTH-1:0];
    if (w_shr > MAXV) begin
      o_res = MAXV[WIDTH-1:0];
    end else if (w_shr < MINV) begin
      o_res = MINV[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/dual_dot_unpack.sv
// Purpose : split a packed dual dot-product P word into j/k lanes, add bias, requantize.
// Latency : 2 cycles from accepted last beat to out_valid.
// Backpressure: out_ready low holds outputs; stage 1 then holds and p_ready drops.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   p_valid/p_ready       packed P beat handshake; p_data = {ji, ki}, p_last marks final tap
//   bias_j, bias_k        signed lane biases, taken with the last beat
//   out_valid/out_ready   result pair handshake; out_j/out_k signed WIDTH-bit results
//   tap_err               sticky flag: dot product length differed from NTAPS
module dual_dot_unpack
  import int8_pack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NTAPS = 64,
  parameter int SHIFT = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   p_valid,
  output logic                   p_ready,
  input  logic [P_WIDTH-1:0]     p_data,
  input  logic                   p_last,
  input  logic [JI_W(WIDTH)-1:0] bias_j,
  input  logic [JI_W(WIDTH)-1:0] bias_k,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_j,
  output logic [WIDTH-1:0]       out_k,
  output logic                   tap_err
);

  localparam int JW = JI_W(WIDTH);
  localparam int KW = KI_W(WIDTH);
  localparam int AW = JW + 1;
  localparam int CW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [CW-1:0] LAST_TAP = CW'(NTAPS - 1);

  logic                 r_s1_valid;
  logic signed [AW-1:0] r_s1_j;
  logic signed [AW-1:0] r_s1_k;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_out_j;
  logic [WIDTH-1:0]     r_out_k;
  logic [CW-1:0]        r_tap_cnt;
  logic                 r_tap_err;

  logic                 w_adv;
  logic                 w_accept;
  logic                 w_load;
  logic signed [AW-1:0] w_ji_ext;
  logic signed [AW-1:0] w_ki_ext;
  logic signed [AW-1:0] w_borrow;
  logic signed [AW-1:0] w_bj_ext;
  logic signed [AW-1:0] w_bk_ext;
  logic signed [AW-1:0] w_sum_j;
  logic signed [AW-1:0] w_sum_k;
  logic [WIDTH-1:0]     w_rq_j;
  logic [WIDTH-1:0]     w_rq_k;

  assign w_adv    = !r_out_valid || out_ready;
  assign p_ready  = !r_s1_valid || w_adv;
  assign w_accept = p_valid && p_ready;
  assign w_load   = w_accept && p_last;

  // The DSP packs j*2^KW + k, so a negative k borrows one from the j field.
  // Adding back the sign bit of k restores the true j value.
  assign w_ji_ext = {{(AW-JW){p_data[P_WIDTH-1]}}, p_data[P_WIDTH-1:KW]};
  assign w_ki_ext = {{(AW-KW){p_data[KW-1]}}, p_data[KW-1:0]};
  assign w_borrow = {{(AW-1){1'b0}}, p_data[KW-1]};
  assign w_bj_ext = {bias_j[JW-1], bias_j};
  assign w_bk_ext = {bias_k[JW-1], bias_k};
  assign w_sum_j  = w_ji_ext + w_borrow + w_bj_ext;
  assign w_sum_k  = w_ki_ext + w_bk_ext;

  // Stage 1 payload: loaded only by an accepted last beat (p_ready already
  // guarantees the previous occupant has moved on or is moving this cycle).
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_s1_j <= w_sum_j;
      r_s1_k <= w_sum_k;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_j     <= '0;
      r_out_k     <= '0;
    end else begin
      if (p_ready) begin
        r_s1_valid <= w_load;
      end
      if (w_adv) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_j <= w_rq_j;
          r_out_k <= w_rq_k;
        end
      end
    end
  end

  // Tap accounting: a correct dot product is NTAPS-1 non-last beats then one last beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tap_cnt <= '0;
      r_tap_err <= 1'b0;
    end else if (w_accept) begin
      if (p_last) begin
        r_tap_cnt <= '0;
        if (r_tap_cnt != LAST_TAP) begin
          r_tap_err <= 1'b1;
        end
      end else if (r_tap_cnt == LAST_TAP) begin
        r_tap_cnt <= '0;
        r_tap_err <= 1'b1;
      end else begin
        r_tap_cnt <= r_tap_cnt + 1'b1;
      end
    end
  end

  dual_dot_requant #(.WIDTH(WIDTH), .SHIFT(SHIFT)) u_rq_j (
    .i_acc (r_s1_j),
    .o_res (w_rq_j)
  );

  dual_dot_requant #(.WIDTH(WIDTH), .SHIFT(SHIFT)) u_rq_k (
    .i_acc (r_s1_k),
    .o_res (w_rq_k)
  );

  assign out_valid = r_out_valid;
  assign out_j     = r_out_j;
  assign out_k     = r_out_k;
  assign tap_err   = r_tap_err;

endmodule

// File: tb/tb_dual_dot_unpack.sv
module tb_dual_dot_unpack;

  localparam int W  = 8;
  localparam int NT = 4;
  localparam int SH = 7;

  typedef struct {
    int j;
    int k;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        p_valid = 1'b0;
  logic        p_ready;
  logic [47:0] p_data = '0;
  logic        p_last = 1'b0;
  logic [31:0] bias_j = '0;
  logic [31:0] bias_k = '0;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_j;
  logic [7:0]  out_k;
  logic        tap_err;

  logic        p0_valid = 1'b0;
  logic        p0_ready;
  logic [47:0] p0_data = '0;
  logic        p0_last = 1'b0;
  logic [31:0] bias0_j = '0;
  logic [31:0] bias0_k = '0;
  logic        out0_valid;
  logic        out0_ready = 1'b1;
  logic [7:0]  out0_j;
  logic [7:0]  out0_k;
  logic        tap0_err;

  int    n_vec = 0;
  int    n_mis = 0;
  pair_t exp_q[$];
  int    n_pushed = 0;
  int    n_got = 0;
  bit    bp_mode = 1'b0;
  logic  or_force = 1'b1;
  bit    mon_pr = 1'b0;
  int    pr_low = 0;

  always #5 clk = ~clk;

  dual_dot_unpack #(.WIDTH(W), .NTAPS(NT), .SHIFT(SH)) u_dut (
    .clk(clk), .rst_n(rst_n), .p_valid(p_valid), .p_ready(p_ready), .p_data(p_data),
    .p_last(p_last), .bias_j(bias_j), .bias_k(bias_k), .out_valid(out_valid),
    .out_ready(out_ready), .out_j(out_j), .out_k(out_k), .tap_err(tap_err)
  );

  dual_dot_unpack #(.WIDTH(W), .NTAPS(1), .SHIFT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .p_valid(p0_valid), .p_ready(p0_ready), .p_data(p0_data),
    .p_last(p0_last), .bias_j(bias0_j), .bias_k(bias0_k), .out_valid(out0_valid),
    .out_ready(out0_ready), .out_j(out0_j), .out_k(out0_k), .tap_err(tap0_err)
  );

  task automatic chk(input string nm, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_mis++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  // Reference: round half up, floor-divide by 2^SH, clamp to signed W bits.
  function automatic int rq(input longint v);
    longint r;
    r = v + (longint'(1) << (SH - 1));
    r = r >>> SH;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [47:0] d, input bit last,
                           input logic [31:0] bj, input logic [31:0] bk);
    bit rdy;
    int guard;
    guard   = 0;
    p_valid = 1'b1;
    p_data  = d;
    p_last  = last;
    bias_j  = bj;
    bias_k  = bk;
    do begin
      @(negedge clk);
      rdy = p_ready;
      @(posedge clk);
      guard++;
    end while (!rdy && guard < 500);
    if (!rdy) chk("accept_timeout_cycles", guard, 0);
    #1;
    p_valid = 1'b0;
    p_last  = 1'b0;
  endtask

  // Packs the true lane values the way the MACC chain does (j*2^16 + k) and
  // records the expected pair once the last beat is accepted.
  task automatic send_dot(input int nb, input longint j, input longint k,
                          input longint bj, input longint bk,
                          input bit use_req, input int rj, input int rk);
    longint      pv;
    logic [47:0] d;
    pair_t       e;
    for (int b = 0; b < nb - 1; b++) begin
      send_beat(48'({$urandom, $urandom}), 1'b0, $urandom, $urandom);
    end
    pv = j * 65536 + k;
    d  = pv[47:0];
    send_beat(d, 1'b1, bj[31:0], bk[31:0]);
    if (use_req) begin
      e.j = rj;
      e.k = rk;
    end else begin
      e.j = rq(j + bj);
      e.k = rq(k + bk);
    end
    exp_q.push_back(e);
    n_pushed++;
  endtask

  task automatic send_rand_dot(input int nb);
    longint j, k, bj, bk;
    j  = longint'($urandom_range(0, 65535)) - 32768;
    k  = longint'($urandom_range(0, 65535)) - 32768;
    bj = longint'($urandom_range(0, 8191)) - 4096;
    bk = longint'($urandom_range(0, 8191)) - 4096;
    send_dot(nb, j, k, bj, bk, 1'b0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  // out_ready driver: forced level or random backpressure.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = bp_mode ? 1'($urandom_range(0, 1)) : or_force;
    end
  end

  // Monitor: scoreboard pop on every output handshake, plus hold checks while stalled.
  initial begin
    pair_t      e;
    logic       pv;
    logic       pr;
    logic [7:0] pj;
    logic [7:0] pk;
    pv = 1'b0;
    pr = 1'b1;
    pj = '0;
    pk = '0;
    forever begin
      @(negedge clk);
      if (mon_pr && !p_ready) pr_low++;
      if (rst_n && pv && !pr) begin
        chk("hold_stable", {out_valid, out_j, out_k}, {1'b1, pj, pk});
      end
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL stray_pair: actual j=%0d k=%0d required no output",
                   $signed(out_j), $signed(out_k));
        end else begin
          e = exp_q.pop_front();
          chk("out_j", $signed(out_j), e.j);
          chk("out_k", $signed(out_k), e.k);
          n_got++;
        end
      end
      pv = rst_n & out_valid;
      pr = out_ready;
      pj = out_j;
      pk = out_k;
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_j", out_j, 0);
    chk("rst_out_k", out_k, 0);
    chk("rst_tap_err", tap_err, 0);
    chk("rst_out0_valid", out0_valid, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("p_ready_after_rst", p_ready, 1);
    step();

    // ji field 16384 with ki -16256 means true j = 16385; 128 saturates to 127.
    send_dot(NT, 16385, -16256, 0, 0, 1'b1, 127, -127);
    @(negedge clk);
    chk("latency_n1_valid", out_valid, 0);
    @(negedge clk);
    chk("latency_n2_valid", out_valid, 1);
    step();

    // Sustained throughput
    mon_pr = 1'b1;
    repeat (100) send_rand_dot(NT);
    mon_pr = 1'b0;
    chk("p_ready_low_cycles", pr_low, 0);
    chk("tap_err_clean", tap_err, 0);
    drain();

    // Full pipeline under a 5-cycle stall
    or_force = 1'b0;
    send_rand_dot(NT);
    send_rand_dot(NT);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_p_ready", p_ready, 0);
      chk("stall_out_valid", out_valid, 1);
    end
    or_force = 1'b1;
    drain();

    // Random backpressure
    bp_mode = 1'b1;
    repeat (50) send_rand_dot(NT);
    bp_mode = 1'b0;
    drain();

    // Short dot product (last on 3rd beat)
    send_rand_dot(3);
    @(negedge clk);
    chk("tap_err_short", tap_err, 1);
    step();
    repeat (5) send_rand_dot(NT);
    drain();
    chk("tap_err_sticky", tap_err, 1);

    // Reset with two pairs in flight
    or_force = 1'b0;
    send_rand_dot(NT);
    send_rand_dot(NT);
    rst_n = 1'b0;
    n_pushed = n_pushed - exp_q.size();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_tap_err", tap_err, 0);
    step();
    rst_n = 1'b1;
    or_force = 1'b1;
    @(negedge clk);
    chk("midrst_p_ready", p_ready, 1);
    step();
    repeat (5) step();

    // Long dot product: non-last beat at count NTAPS-1 wraps and flags
    send_rand_dot(5);
    @(negedge clk);
    chk("tap_err_long", tap_err, 1);
    step();
    drain();

    // SHIFT=0, NTAPS=1 instance: 153 saturates to 127, ki -58 passes through.
    p0_valid = 1'b1;
    p0_data  = {32'sd152, 16'hFFC6};
    p0_last  = 1'b1;
    @(negedge clk);
    chk("p0_ready", p0_ready, 1);
    step();
    p0_valid = 1'b0;
    p0_last  = 1'b0;
    @(negedge clk);
    chk("p0_latency_n1", out0_valid, 0);
    @(negedge clk);
    chk("p0_out_valid", out0_valid, 1);
    chk("p0_out_j", $signed(out0_j), 127);
    chk("p0_out_k", $signed(out0_k), -58);
    chk("p0_tap_err", tap0_err, 0);
    step();

    drain();
    chk("queue_drained", exp_q.size(), 0);
    chk("pair_count", n_got, n_pushed);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
